// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM state type and width constants for the load/store unit
package lsu_pkg;

    localparam int LSU_ADDR_W     = 32;
    localparam int LSU_MEM_ADDR_W = LSU_ADDR_W - 2;

    // req_size encodings; 2'd3 is illegal
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - combinational byte/half lane extract+extend for loads and merge for stores
//   size        : access size (SZ_B/SZ_H/SZ_W)
//   addr_lo     : byte offset within the word
//   is_unsigned : zero-extend loads instead of sign-extending
//   rword       : word read from memory
//   wdata       : right-aligned store data
//   ldata       : extended load result
//   mword       : rword with the addressed lane replaced by wdata (word size: wdata)
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [31:0] shifted;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        shifted = rword >> {addr_lo, 3'b000};
        bsel    = shifted[7:0];
        hsel    = addr_lo[1] ? rword[31:16] : rword[15:0];
        ldata   = rword;
        mword   = wdata;
        case (size)
            SZ_B: begin
                ldata = {{24{~is_unsigned & bsel[7]}}, bsel};
                mword = rword;
                mword[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ldata = {{16{~is_unsigned & hsel[15]}}, hsel};
                mword = rword;
                mword[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ldata = rword;
                mword = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller FSM between core requests and a word-wide memory port
//   Build option: LSU_RMW_EN enables read-modify-write sub-word stores; otherwise they error.
//   clk, rst         : clock, synchronous active-high reset
//   req_*            : core request (valid/ready handshake), latched on acceptance
//   rsp_valid/rdata/err : single-cycle completion, no backpressure
//   mem_req/we/addr/wdata, mem_gnt : memory request held until granted
//   mem_rvalid/rdata : read return, only honoured while waiting for it
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_RMW_EN
    localparam logic RMW_EN = 1'b1;
`else
    localparam logic RMW_EN = 1'b0;
`endif

    lsu_state_t        state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              req_bad;
    logic [31:0]       ldata;
    logic [31:0]       mword;

    assign accept = req_valid && req_ready;

    // Rejected requests never touch memory: bad size, misalignment, or a
    // sub-word store when the read-modify-write path is not built in.
    assign req_bad = (req_size == 2'd3)
                  || (req_size == SZ_H && req_addr[0])
                  || (req_size == SZ_W && req_addr[1:0] != 2'b00)
                  || (req_we && req_size != SZ_W && !RMW_EN);

    lsu_lane u_lane (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .rword       (rdata_q),
        .wdata       (wdata_q),
        .ldata       (ldata),
        .mword       (mword)
    );

    // Address only changes on acceptance, so it is stable for the whole request.
    assign mem_addr = addr_q[ADDR_W-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_B;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_bad;
                wdata_q <= req_wdata;
            end
            if (state == RD_WAIT && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)                        state_n = RESP;
                    else if (req_we && req_size == SZ_W) state_n = WR_REQ;
                    else                                 state_n = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_n = RD_WAIT;
            end
            RD_WAIT: begin
                // A sub-word store comes through here to fetch the word to merge into.
                if (mem_rvalid) state_n = we_q ? WR_REQ : RESP;
            end
            WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = mword;
                if (mem_gnt) state_n = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'h0 : ldata;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request; it is accepted at the next edge because the DUT is idle.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        total++; if (mem_addr !== 30'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_load(input string name, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] word,
                             input logic [31:0] exp);
        mem_gnt = 1'b1;
        issue(1'b0, size, uns, addr, 32'h0);
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL %s_rdreq: got req=%b we=%b want req=1 we=0", name, mem_req, mem_we); end
        total++; if (mem_addr !== addr[31:2]) begin bad++; $display("FAIL %s_addr: got %h want %h", name, mem_addr, addr[31:2]); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL %s_busy: got ready=%b want 0", name, req_ready); end
        tick();
        total++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL %s_wait: got req=%b rsp=%b want 0 0", name, mem_req, rsp_valid); end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL %s_rsp: got valid=%b err=%b want 1 0", name, rsp_valid, rsp_err); end
        total++; if (rsp_rdata !== exp) begin bad++; $display("FAIL %s_rdata: got %h want %h", name, rsp_rdata, exp); end
        tick();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL %s_done: got valid=%b ready=%b want 0 1", name, rsp_valid, req_ready); end
    endtask

    task automatic test_error(input string name, input logic we, input logic [1:0] size,
                              input logic [31:0] addr);
        mem_gnt = 1'b1;
        issue(we, size, 1'b0, addr, 32'hFFFF_FFFF);
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin bad++; $display("FAIL %s_err: got valid=%b err=%b want 1 1", name, rsp_valid, rsp_err); end
        total++; if (mem_req !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL %s_quiet: got req=%b rdata=%h want 0 0", name, mem_req, rsp_rdata); end
        tick();
        total++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL %s_after: got valid=%b req=%b want 0 0", name, rsp_valid, mem_req); end
    endtask

    task automatic test_store_word;
        mem_gnt = 1'b1;
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL sw_wrreq: got req=%b we=%b want 1 1", mem_req, mem_we); end
        total++; if (mem_addr !== 30'h10) begin bad++; $display("FAIL sw_addr: got %h want 10", mem_addr); end
        total++; if (mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL sw_wdata: got %h want 12345678", mem_wdata); end
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL sw_rsp: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sw_noreq: got %b want 0", mem_req); end
        tick();
    endtask

`ifdef LSU_RMW_EN
    task automatic test_rmw(input string name, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] word,
                            input logic [31:0] exp);
        mem_gnt = 1'b1;
        issue(1'b1, size, 1'b0, addr, wdata);
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL %s_rd: got req=%b we=%b want 1 0", name, mem_req, mem_we); end
        total++; if (mem_addr !== addr[31:2]) begin bad++; $display("FAIL %s_addr: got %h want %h", name, mem_addr, addr[31:2]); end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL %s_wr: got req=%b we=%b want 1 1", name, mem_req, mem_we); end
        total++; if (mem_wdata !== exp) begin bad++; $display("FAIL %s_merge: got %h want %h", name, mem_wdata, exp); end
        total++; if (mem_addr !== addr[31:2]) begin bad++; $display("FAIL %s_waddr: got %h want %h", name, mem_addr, addr[31:2]); end
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL %s_rsp: got v=%b e=%b d=%h want 1 0 0", name, rsp_valid, rsp_err, rsp_rdata); end
        tick();
    endtask
`endif

    task automatic test_subword_store;
`ifdef LSU_RMW_EN
        test_rmw("sb", 2'd0, 32'h21, 32'h0000_00AB, 32'h1122_3344, 32'h1122_AB44);
        test_rmw("sh", 2'd1, 32'h22, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344);
`else
        test_error("sb_norwm", 1'b1, 2'd0, 32'h21);
        test_error("sh_norwm", 1'b1, 2'd1, 32'h22);
`endif
    endtask

    task automatic test_gnt_stall;
        mem_gnt = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        for (int i = 0; i < 5; i++) begin
            // A stray read return while still requesting must not advance anything.
            mem_rvalid = (i == 2);
            mem_rdata  = 32'h0BAD_0BAD;
            total++; if (mem_req !== 1'b1 || mem_addr !== 30'h41 || mem_we !== 1'b0) begin bad++; $display("FAIL stall_hold%0d: got req=%b addr=%h we=%b want 1 41 0", i, mem_req, mem_addr, mem_we); end
            tick();
        end
        mem_rvalid = 1'b0;
        total++; if (mem_req !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_still: got req=%b rsp=%b want 1 0", mem_req, rsp_valid); end
        mem_gnt = 1'b1;
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stall_granted: got req=%b want 0", mem_req); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_rsp: got v=%b d=%h want 1 cafef00d", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        mem_gnt = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle: got ready=%b req=%b rsp=%b want 1 0 0", req_ready, mem_req, rsp_valid); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0) seen++;
            tick();
            mem_rvalid = 1'b0;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_late_rvalid: got %0d stray cycles want 0", seen); end
        total++; if (req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL midrst_final: got ready=%b d=%h want 1 0", req_ready, rsp_rdata); end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;

        test_reset();
        test_load("lw",  2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_load("lb",  2'd0, 1'b0, 32'h13, 32'h80FF_0000, 32'hFFFF_FF80);
        test_load("lbu", 2'd0, 1'b1, 32'h13, 32'h80FF_0000, 32'h0000_0080);
        test_load("lb1", 2'd0, 1'b0, 32'h11, 32'h1234_F678, 32'hFFFF_FFF6);
        test_load("lh",  2'd1, 1'b0, 32'h12, 32'h80FF_0000, 32'hFFFF_80FF);
        test_load("lhu", 2'd1, 1'b1, 32'h12, 32'h80FF_0000, 32'h0000_80FF);
        test_load("lh0", 2'd1, 1'b0, 32'h10, 32'h80FF_7001, 32'h0000_7001);
        test_load("lwu", 2'd2, 1'b1, 32'h14, 32'h8000_0001, 32'h8000_0001);
        test_error("lw_mis", 1'b0, 2'd2, 32'h22);
        test_error("lh_mis", 1'b0, 2'd1, 32'h11);
        test_error("sz3",    1'b0, 2'd3, 32'h20);
        test_error("sw_mis", 1'b1, 2'd2, 32'h41);
        test_store_word();
        test_subword_store();
        test_gnt_stall();
        test_reset_mid();
        test_load("lw_after", 2'd2, 1'b0, 32'h10, 32'h0102_0304, 32'h0102_0304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
